seq_mul_w: RTL
==============

# seq_mul_w

Parametrised sequential multiplier: one multiply of two `W`-bit operands per transaction, each operand unsigned or two's-complement signed, producing a `2W`-bit product. It uses a radix-2 shift-add datapath with valid/ready handshakes on both sides. It is the clocked, width-generic successor to the fixed 8-in/8-out combinational arithmetic blocks, trading latency for area. It sits between an operand producer and a result consumer, either of which may stall.

## Interface
- `W`, default 4: operand width. Legal range is 2..32; the product is `2W` bits wide.
- `clk`  input  1  rising-edge clock, the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  the operand set is presented.
- `in_ready`  output  1  the block can accept operands.
- `a`  input  W  multiplicand.
- `b`  input  W  multiplier.
- `sgn`  input  1  operand interpretation: 1 = both operands two's-complement, 0 = both unsigned. Sampled with the operands.
- `out_valid`  output  1  `p` holds a finished product.
- `out_ready`  input  1  the consumer accepts `p`.
- `p`  output  2W  product, signed or unsigned according to the `sgn` captured with the operands.
- `busy`  output  1  high in RUN or DONE.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `in_ready = 1`.
  - On `in_valid & in_ready`, capture the operands, load counter `cnt = W`, clear the accumulator, and go to RUN.
  - Operand capture when `sgn = 1`: latch `neg = a[W-1] ^ b[W-1]`, and load `|a|` and `|b|` as W-bit unsigned values.
  - When `sgn = 0`: `neg = 0`, and load `a` and `b` raw.
  - `|-2^(W-1)| = 2^(W-1)` fits in W unsigned bits, so no overflow is possible.
- **RUN**
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper half of a `2W+1`-bit accumulator.
  - Then shift the accumulator and the multiplier right by 1, and decrement `cnt`.
  - When `cnt` reaches 1, the final iteration completes and the state goes to DONE.
  - In DONE, `p` is loaded with the accumulator, two's-complement negated modulo `2^(2W)` when `neg = 1`.
- **DONE**
  - `out_valid = 1`, and `p` is held stable.
  - On `out_valid & out_ready`, go to IDLE.
- **Handshake and signal rules**
  - `in_ready` is low in RUN and DONE. Operands presented there are not accepted, and the producer must hold them.
  - No early termination on zero operands: latency is data-independent.
  - `busy` is the inverse of (state == IDLE).
- **Arithmetic range**
  - The signed product range is `[-(2^(W-1))*(2^(W-1)-1), 2^(2W-2)]`, which always fits in `2W` signed bits.
  - The unsigned maximum `(2^W-1)^2` fits in `2W` bits.
  - The product is never truncated or saturated.
- **Reset**
  - `rst_n` low forces IDLE immediately, regardless of the clock.
  - Reset values: `out_valid = 0`, `p = 0`, `busy = 0`; `in_ready = 1` during and after reset.
  - An operation in flight is discarded; no partial result appears.

## Timing
- Let operands be accepted at rising edge t.
- RUN occupies edges t+1 .. t+W, one iteration per edge.
- `p` and `out_valid` are registered and valid after edge t+W. Latency from acceptance is W cycles.
- If `out_ready` is high in the first DONE cycle, IDLE is reached after edge t+W+1, and `in_ready` is high in the following cycle.
- Minimum issue interval: W+2 cycles.
- `in_ready`, `out_valid` and `busy` decode from state registers only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Back-pressure: `p` and `out_valid` stay constant for any number of cycles with `out_ready` low.
- Reset deassertion is synchronised externally; the first acceptance is possible at the first rising edge with `rst_n` high.

## Test plan
- **Unsigned full-scale**: W=4, `sgn=0`, `a=15`, `b=15`, `out_ready=1`.
  - `out_valid` after 4 edges with `p=0xE1` (225).
  - `in_ready` returns 2 cycles later.
- **Signed corners**: W=4, `sgn=1`.
  - `a=-8`, `b=-8` -> `p=0x40` (64).
  - `a=-8`, `b=7` -> `p=0xC8` (-56).
  - `a=-1`, `b=1` -> `p=0xFF`.
- **Back-pressure**: W=4, `a=3`, `b=5`, `out_ready` low for 6 cycles after `out_valid`.
  - `p=0x0F` is held stable and `out_valid` stays 1 throughout.
  - `in_ready` stays 0 while `in_valid` is held with new operands.
  - Those operands are accepted only after the first result is consumed.
- **Mid-operation reset**: W=8, `a=200`, `b=100`; pulse `rst_n` low 2 edges into RUN.
  - `out_valid=0`, `p=0`, `busy=0`, `in_ready=1` immediately.
  - A subsequent `a=200`, `b=100` yields `p=0x4E20` (20000) after 8 cycles.
- **Zero and back-to-back**: W=4, issue `0*13` then `13*0` with `in_valid` and `out_ready` held high.
  - Both give `p=0`.
  - Latency is 4 cycles each, and acceptances are spaced exactly 6 cycles apart.
- **Width sweep**: W=2, 8, 32, with 1000 random `(a, b, sgn)` each, checked against a reference model.
  - Every product matches exactly.
  - Latency equals W every time.

Source files
------------

// File: rtl/seq_mul_w.sv
// seq_mul_w: radix-2 shift-add sequential multiplier, W-bit operands, 2W-bit product.
// Operands are unsigned or two's-complement (chosen per transaction by sgn). Signed
// operands are reduced to magnitudes on capture, and the sign is reapplied when the
// product is stored. Latency is always W cycles from acceptance to out_valid.
module seq_mul_w #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sgn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    // Counter must hold the value W itself.
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   mcand_reg;
    // Upper half: running partial sum. Lower half: multiplier bits not yet consumed.
    // The carry out of each add is the extra bit of the 2W+1 accumulator; it is shifted
    // straight back into the 2W-bit register, so it never needs its own flop.
    logic [2*W-1:0] acc_reg;
    logic           neg_reg;
    logic [2*W-1:0] p_reg;

    logic           accept;
    logic           take;
    logic           last_iter;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     sum;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] prod_final;

    assign accept    = (state_reg == IDLE) && in_valid;
    assign take      = (state_reg == DONE) && out_ready;
    assign last_iter = (state_reg == RUN) && (cnt_reg == CW'(1));

    // |-2^(W-1)| = 2^(W-1) still fits in W unsigned bits, so negation cannot overflow.
    assign a_mag = (sgn && a[W-1]) ? -a : a;
    assign b_mag = (sgn && b[W-1]) ? -b : b;

    // One shift-add step: add multiplicand to the upper half when the multiplier LSB is set,
    // then shift the whole accumulator (carry included) right by one.
    assign sum        = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    assign acc_next   = {sum, acc_reg[W-1:1]};
    assign prod_final = neg_reg ? -acc_next : acc_next;

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    if (take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode from the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture operands, iterate W times, store the signed/unsigned product once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            mcand_reg <= '0;
            acc_reg   <= '0;
            neg_reg   <= 1'b0;
            p_reg     <= '0;
        end else if (accept) begin
            cnt_reg   <= CW'(W);
            mcand_reg <= a_mag;
            acc_reg   <= {{W{1'b0}}, b_mag};
            neg_reg   <= sgn & (a[W-1] ^ b[W-1]);
        end else if (state_reg == RUN) begin
            cnt_reg <= cnt_reg - CW'(1);
            acc_reg <= acc_next;
            if (last_iter) begin
                p_reg <= prod_final;
            end
        end
    end

    assign p = p_reg;

endmodule
